dmem_ls_responder: RTL and testbench

- Memory-side responder for the core's load/store requests.
- Accepts one request at a time over a valid/ready handshake, typed by load_store_type_e from risc_v_32_i_pkg.
- Owns a word-organised synchronous data RAM. Stores use byte-lane write enables; load data is aligned and then sign- or zero-extended.
- Returns one response per request. Sits between the core's load/store path and the data memory.

---
 rtl/dmem_ls_responder.sv | 166 ++++++++++++++++
 tb/tb_dmem_ls_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ls_responder.sv
// Load/store responder owning a word-organised data RAM with byte-lane writes.
// Optional misalignment trapping is enabled by defining DMEM_MISALIGN_TRAP_EN.
`timescale 1ns/1ps

package risc_v_32_i_pkg;
    localparam int XLEN                = 32;
    localparam int LOAD_STORE_TYPE_LEN = 4;

    typedef enum logic [LOAD_STORE_TYPE_LEN-1:0] {
        L_W    = 4'd0,
        L_H    = 4'd1,
        L_HU   = 4'd2,
        L_B    = 4'd3,
        L_BU   = 4'd4,
        S_W    = 4'd5,
        S_H    = 4'd6,
        S_B    = 4'd7,
        LS_N_A = 4'd8
    } load_store_type_e;
endpackage

module dmem_ls_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          req_valid,
    output logic                                          req_ready,
    input  logic [ADDR_WIDTH-1:0]                         req_addr,
    input  logic [risc_v_32_i_pkg::LOAD_STORE_TYPE_LEN-1:0] req_type,
    input  logic [XLEN-1:0]                               req_wdata,
    output logic                                          rsp_valid,
    input  logic                                          rsp_ready,
    output logic [XLEN-1:0]                               rsp_rdata,
    output logic                                          rsp_err,
    output logic                                          busy
);
    import risc_v_32_i_pkg::load_store_type_e;
    import risc_v_32_i_pkg::L_W;
    import risc_v_32_i_pkg::L_H;
    import risc_v_32_i_pkg::L_HU;
    import risc_v_32_i_pkg::L_B;
    import risc_v_32_i_pkg::L_BU;
    import risc_v_32_i_pkg::S_W;
    import risc_v_32_i_pkg::S_H;
    import risc_v_32_i_pkg::S_B;
    import risc_v_32_i_pkg::LS_N_A;

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, MEM, RESP} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       off_q;
    load_store_type_e type_q;
    logic [XLEN-1:0]  wdata_q;
    logic             err_q;
    logic [XLEN-1:0]  rd_word;
    logic [XLEN-1:0]  mem [DEPTH_WORDS];

    logic             type_bad, range_bad, misalign, req_err;
    logic [3:0]       be;
    logic [XLEN-1:0]  wd;
    logic             we;
    logic [15:0]      half_sel;
    logic [7:0]       byte_sel;
    logic [XLEN-1:0]  load_data;

    // Error classification is done on the raw request so it can be captured with it.
    always_comb begin
        type_bad  = (req_type >= LS_N_A);
        range_bad = ((req_addr >> (IDX_W + 2)) != '0);
        misalign  = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((req_type == L_W || req_type == S_W) && req_addr[1:0] != 2'b00)
            misalign = 1'b1;
        if ((req_type == L_H || req_type == L_HU || req_type == S_H) && req_addr[0])
            misalign = 1'b1;
`endif
        req_err = type_bad || range_bad || misalign;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            off_q   <= '0;
            type_q  <= LS_N_A;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                idx_q   <= req_addr[2 +: IDX_W];
                off_q   <= req_addr[1:0];
                type_q  <= load_store_type_e'(req_type);
                wdata_q <= req_wdata;
                err_q   <= req_err;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = MEM;
            MEM:     state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Narrow stores replicate their data so the lane mask alone selects the target bytes.
    always_comb begin
        be = 4'b0000;
        wd = wdata_q;
        case (type_q)
            S_W: be = 4'b1111;
            S_H: begin
                be = off_q[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata_q[15:0]}};
            end
            S_B: begin
                be = 4'b0001 << off_q;
                wd = {4{wdata_q[7:0]}};
            end
            default: ;
        endcase
    end

    assign we = (state_q == MEM) && !err_q;

    always_ff @(posedge clk) begin
        if (state_q == MEM) begin
            for (int b = 0; b < 4; b++) begin
                if (we && be[b])
                    mem[idx_q][8*b +: 8] <= wd[8*b +: 8];
            end
            rd_word <= mem[idx_q];
        end
    end

    always_comb begin
        half_sel  = off_q[1] ? rd_word[31:16] : rd_word[15:0];
        byte_sel  = rd_word[{off_q, 3'b000} +: 8];
        load_data = '0;
        case (type_q)
            L_W:     load_data = rd_word;
            L_H:     load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            L_HU:    load_data = {{(XLEN-16){1'b0}}, half_sel};
            L_B:     load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            L_BU:    load_data = {{(XLEN-8){1'b0}}, byte_sel};
            default: load_data = '0;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_err   = (state_q == RESP) && err_q;
    assign rsp_rdata = ((state_q == RESP) && !err_q) ? load_data : '0;

endmodule

// File: tb/tb_dmem_ls_responder.sv
// Directed bench for dmem_ls_responder: byte-addressed reference model plus literal expectations.
`timescale 1ns/1ps

module tb_dmem_ls_responder;
    localparam int XLEN        = 32;
    localparam int DEPTH_WORDS = 1024;
    localparam int ADDR_WIDTH  = 32;

    localparam logic [3:0] T_LW = 4'd0, T_LH = 4'd1, T_LHU = 4'd2, T_LB = 4'd3, T_LBU = 4'd4;
    localparam logic [3:0] T_SW = 4'd5, T_SH = 4'd6, T_SB = 4'd7, T_NA = 4'd8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr = '0;
    logic [3:0]            req_type = '0;
    logic [XLEN-1:0]       req_wdata = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [XLEN-1:0]       rsp_rdata;
    logic                  rsp_err;
    logic                  busy;

    dmem_ls_responder #(
        .XLEN(XLEN), .DEPTH_WORDS(DEPTH_WORDS), .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_type(req_type), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } rsp_t;

    int          checks = 0;
    int          errors = 0;
    rsp_t        exp_q[$];
    bit [7:0]    mdl [int unsigned];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Byte-level memory model: accesses are truncated to natural alignment unless trapping.
    task automatic model_apply(input logic [31:0] addr, input logic [3:0] typ,
                               input logic [31:0] wdata, output rsp_t r);
        int          size;
        bit          is_store, is_signed;
        logic [31:0] base, val;
        r.rd  = 32'h0;
        r.err = 1'b0;
        case (typ)
            T_LW, T_SW:        size = 4;
            T_LH, T_LHU, T_SH: size = 2;
            T_LB, T_LBU, T_SB: size = 1;
            default:           size = 1;
        endcase
        is_store  = (typ == T_SW || typ == T_SH || typ == T_SB);
        is_signed = (typ == T_LH || typ == T_LB);
        if (typ >= T_NA || addr >= 32'(4 * DEPTH_WORDS)) r.err = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (size > 1 && (addr % size) != 0) r.err = 1'b1;
`endif
        if (r.err) return;
        base = addr - (addr % size);
        if (is_store) begin
            for (int i = 0; i < size; i++) mdl[base + i] = wdata[8*i +: 8];
        end else begin
            val = 32'h0;
            for (int i = 0; i < size; i++) val = val | (32'(mdl[base + i]) << (8*i));
            if (is_signed && val[8*size-1] && size < 4) val = val | (32'hFFFF_FFFF << (8*size));
            r.rd = val;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rsp: got rsp_valid 1 expected 0");
            end else begin
                check_output("cmp rsp_rdata", rsp_rdata, exp_q[0].rd);
                check_output("cmp rsp_err", {31'b0, rsp_err}, {31'b0, exp_q[0].err});
            end
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_output({name, " req_ready"}, {31'b0, req_ready}, 32'd1);
    endtask

    task automatic apply_stimulus(input string name, input logic [31:0] addr, input logic [3:0] typ,
                                  input logic [31:0] wdata, input int hold,
                                  input logic [31:0] lit_rd, input logic lit_err);
        rsp_t        r;
        logic [31:0] got_rd;
        logic        got_err;
        wait_ready(name);
        model_apply(addr, typ, wdata, r);
        check_output({name, " model_rd"}, r.rd, lit_rd);
        check_output({name, " model_err"}, {31'b0, r.err}, {31'b0, lit_err});
        exp_q.push_back(r);
        req_addr  = addr;
        req_type  = typ;
        req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check_output({name, " mem_valid"}, {31'b0, rsp_valid}, 32'd0);
        check_output({name, " mem_ready"}, {31'b0, req_ready}, 32'd0);
        check_output({name, " mem_busy"}, {31'b0, busy}, 32'd1);
        @(negedge clk);
        check_output({name, " latency"}, {31'b0, rsp_valid}, 32'd1);
        got_rd  = rsp_rdata;
        got_err = rsp_err;
        check_output({name, " rdata"}, got_rd, lit_rd);
        check_output({name, " err"}, {31'b0, got_err}, {31'b0, lit_err});
        repeat (hold) begin
            @(negedge clk);
            check_output({name, " hold_valid"}, {31'b0, rsp_valid}, 32'd1);
            check_output({name, " hold_ready"}, {31'b0, req_ready}, 32'd0);
            check_output({name, " hold_rdata"}, rsp_rdata, lit_rd);
            check_output({name, " hold_err"}, {31'b0, rsp_err}, {31'b0, lit_err});
        end
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        if (exp_q.size() > 0) r = exp_q.pop_front();
        @(negedge clk);
        check_output({name, " done_valid"}, {31'b0, rsp_valid}, 32'd0);
        check_output({name, " done_ready"}, {31'b0, req_ready}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check_output({name, " req_ready"}, {31'b0, req_ready}, 32'd1);
        check_output({name, " rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        check_output({name, " rsp_rdata"}, rsp_rdata, 32'd0);
        check_output({name, " rsp_err"}, {31'b0, rsp_err}, 32'd0);
        check_output({name, " busy"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_reset");

        apply_stimulus("sw0",    32'h0000, T_SW,  32'h0BADF00D, 0, 32'h0,        1'b0);
        apply_stimulus("sw10",   32'h0010, T_SW,  32'hDEADBEEF, 0, 32'h0,        1'b0);
        apply_stimulus("lw10",   32'h0010, T_LW,  32'h0,        0, 32'hDEADBEEF, 1'b0);
        apply_stimulus("sb13",   32'h0013, T_SB,  32'h00000080, 0, 32'h0,        1'b0);
        apply_stimulus("lb13",   32'h0013, T_LB,  32'h0,        0, 32'hFFFFFF80, 1'b0);
        apply_stimulus("lbu13",  32'h0013, T_LBU, 32'h0,        0, 32'h00000080, 1'b0);
        apply_stimulus("lw10b",  32'h0010, T_LW,  32'h0,        0, 32'h80ADBEEF, 1'b0);
        apply_stimulus("lb11",   32'h0011, T_LB,  32'h0,        0, 32'hFFFFFFBE, 1'b0);
        apply_stimulus("sw20",   32'h0020, T_SW,  32'h0,        0, 32'h0,        1'b0);
        apply_stimulus("sh22",   32'h0022, T_SH,  32'hABCD8001, 0, 32'h0,        1'b0);
        apply_stimulus("lh22",   32'h0022, T_LH,  32'h0,        0, 32'hFFFF8001, 1'b0);
        apply_stimulus("lhu22",  32'h0022, T_LHU, 32'h0,        0, 32'h00008001, 1'b0);
        apply_stimulus("lh20",   32'h0020, T_LH,  32'h0,        0, 32'h00000000, 1'b0);
        apply_stimulus("badtyp", 32'h0010, T_NA,  32'h12345678, 0, 32'h0,        1'b1);
        apply_stimulus("lw10c",  32'h0010, T_LW,  32'h0,        0, 32'h80ADBEEF, 1'b0);
        apply_stimulus("oor",    32'h1000, T_SW,  32'hFFFFFFFF, 0, 32'h0,        1'b1);
        apply_stimulus("lw0",    32'h0000, T_LW,  32'h0,        0, 32'h0BADF00D, 1'b0);
        apply_stimulus("lwhold", 32'h0010, T_LW,  32'h0,        5, 32'h80ADBEEF, 1'b0);
        apply_stimulus("sw40",   32'h0040, T_SW,  32'h11223344, 0, 32'h0,        1'b0);

        // Store abandoned by reset while in MEM: must not reach the RAM.
        wait_ready("rst_store");
        req_addr  = 32'h0040;
        req_type  = T_SW;
        req_wdata = 32'h55555555;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check_output("rst_store busy", {31'b0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_abort");

        apply_stimulus("lw40",   32'h0040, T_LW,  32'h0,        0, 32'h11223344, 1'b0);
        apply_stimulus("lhu12",  32'h0012, T_LHU, 32'h0,        0, 32'h000080AD, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        apply_stimulus("lw12",   32'h0012, T_LW,  32'h0,        0, 32'h0,        1'b1);
        apply_stimulus("sh11",   32'h0011, T_SH,  32'h00007777, 0, 32'h0,        1'b1);
        apply_stimulus("lw10d",  32'h0010, T_LW,  32'h0,        0, 32'h80ADBEEF, 1'b0);
`else
        apply_stimulus("lw12",   32'h0012, T_LW,  32'h0,        0, 32'h80ADBEEF, 1'b0);
        apply_stimulus("lh13",   32'h0013, T_LH,  32'h0,        0, 32'hFFFF80AD, 1'b0);
`endif

        check_output("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
